wb_port_arbiter: RTL and testbench

//  Shares the register file's single write port between N_REQ writeback requesters,
//  e.g. the single-cycle ALU/load path and a multi-cycle mul/div unit.

---
 rtl/wb_port_arbiter_if.sv | 25 ++
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback request bundle: one valid/ready handshake plus dest register and data per requester.
// Requester k occupies rd_addr bits [5k+4:5k] and data bits [X_LEN*k+X_LEN-1:X_LEN*k].
interface wb_port_arbiter_if #(
  parameter int X_LEN = 32,
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [5*N_REQ-1:0]     req_rd_addr;
  logic [X_LEN*N_REQ-1:0] req_data;

  modport master (
    output req_valid,
    output req_rd_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among N_REQ writeback requesters.
// The grant is combinational; the write port and the committed-write counter are registered.
module wb_port_arbiter #(
  parameter int X_LEN = 32,
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  wb_port_arbiter_if.slave         req,
  output logic                     REG_WRITE_o,
  output logic [4:0]               rd_addr_o,
  output logic [X_LEN-1:0]         wb_data_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic [CNT_W-1:0]         wr_count_o
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int ADDR_W = 5;

  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_ptr_d;
  logic              reg_write_q;
  logic [4:0]        rd_addr_q;
  logic [X_LEN-1:0]  wb_data_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ID_W:0]     cand_sum_s;
  logic [ID_W-1:0]   cand_idx_s;
  logic              found_s;
  logic              accept_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [N_REQ-1:0]  ready_s;
  logic [4:0]        gnt_addr_s;
  logic [X_LEN-1:0]  gnt_data_s;
  logic              commit_s;

  // Pick the first valid requester at or after rr_ptr, wrapping at N_REQ-1; no grant during reset.
  always_comb begin
    cand_sum_s = '0;
    cand_idx_s = '0;
    found_s    = 1'b0;
    gnt_idx_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum_s = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand_sum_s >= (ID_W+1)'(N_REQ)) begin
        cand_idx_s = ID_W'(cand_sum_s - (ID_W+1)'(N_REQ));
      end else begin
        cand_idx_s = cand_sum_s[ID_W-1:0];
      end
      if (!found_s && req.req_valid[cand_idx_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = cand_idx_s;
      end else begin
        found_s   = found_s;
      end
    end
    accept_s = found_s & ~rst_i;
    ready_s  = '0;
    if (accept_s) begin
      ready_s[gnt_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Steer the granted requester's payload and compute the pointer past it.
  always_comb begin
    gnt_addr_s = req.req_rd_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
    gnt_data_s = req.req_data[int'(gnt_idx_s)*X_LEN +: X_LEN];
    commit_s   = accept_s && (gnt_addr_s != 5'd0);
    if (!accept_s) begin
      rr_ptr_d = rr_ptr_q;
    end else if (gnt_idx_s == ID_W'(N_REQ-1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = gnt_idx_s + ID_W'(1);
    end
  end

  assign req.req_ready = ready_s;

  // Write-port register stage; x0 writes are consumed without raising the write enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= 5'd0;
      wb_data_q   <= '0;
      grant_id_q  <= '0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      reg_write_q <= commit_s;
      if (accept_s) begin
        rd_addr_q  <= gnt_addr_s;
        wb_data_q  <= gnt_data_s;
        grant_id_q <= gnt_idx_s;
      end else begin
        rd_addr_q  <= rd_addr_q;
        wb_data_q  <= wb_data_q;
        grant_id_q <= grant_id_q;
      end
      if (commit_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

  assign REG_WRITE_o = reg_write_q;
  assign rd_addr_o   = rd_addr_q;
  assign wb_data_o   = wb_data_q;
  assign grant_id_o  = grant_id_q;
  assign wr_count_o  = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a 16-bit-counter instance for arbitration and a
// 2-bit-counter instance for counter saturation, both with two requesters.
module tb_wb_port_arbiter;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  wb_port_arbiter_if #(.X_LEN(32), .N_REQ(2)) bus_a ();
  wb_port_arbiter_if #(.X_LEN(32), .N_REQ(2)) bus_b ();

  logic        a_we;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic [0:0]  a_gid;
  logic [15:0] a_cnt;
  logic        b_we;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic [0:0]  b_gid;
  logic [1:0]  b_cnt;

  wb_port_arbiter #(.X_LEN(32), .N_REQ(2), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .req(bus_a.slave),
    .REG_WRITE_o(a_we), .rd_addr_o(a_rd), .wb_data_o(a_data),
    .grant_id_o(a_gid), .wr_count_o(a_cnt)
  );

  wb_port_arbiter #(.X_LEN(32), .N_REQ(2), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req(bus_b.slave),
    .REG_WRITE_o(b_we), .rd_addr_o(b_rd), .wb_data_o(b_data),
    .grant_id_o(b_gid), .wr_count_o(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    bus_a.req_valid   = 2'b00;
    bus_a.req_rd_addr = 10'd0;
    bus_a.req_data    = 64'd0;
    bus_b.req_valid   = 2'b00;
    bus_b.req_rd_addr = 10'd0;
    bus_b.req_data    = 64'd0;

    // reset held two cycles, req0 already valid
    bus_a.req_rd_addr = {5'd0, 5'd5};
    bus_a.req_data    = {32'h0, 32'hAAAA0005};
    bus_a.req_valid   = 2'b01;
    tick();
    tick();
    chk("rst_we",    a_we,   1'b0);
    chk("rst_rd",    a_rd,   5'd0);
    chk("rst_data",  a_data, 32'h0);
    chk("rst_gid",   a_gid,  1'b0);
    chk("rst_cnt",   a_cnt,  16'd0);
    chk("rst_ready", bus_a.req_ready, 2'b00);
    rst = 1'b0;
    #1;
    chk("t1_ready", bus_a.req_ready, 2'b01);
    tick();
    chk("t1_we",   a_we,   1'b1);
    chk("t1_rd",   a_rd,   5'd5);
    chk("t1_data", a_data, 32'hAAAA0005);
    chk("t1_gid",  a_gid,  1'b0);
    chk("t1_cnt",  a_cnt,  16'd1);
    bus_a.req_valid = 2'b00;
    #1;
    chk("idle_ready", bus_a.req_ready, 2'b00);
    tick();
    chk("idle_we",   a_we, 1'b0);
    chk("idle_rd",   a_rd, 5'd5);
    chk("idle_cnt",  a_cnt, 16'd1);

    // both valid from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t2_cnt0", a_cnt, 16'd0);
    chk("t2_we0",  a_we,  1'b0);
    bus_a.req_rd_addr = {5'd2, 5'd1};
    bus_a.req_data    = {32'h200, 32'h100};
    bus_a.req_valid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_ready", bus_a.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("t2_gid",  a_gid,  (k % 2 == 0) ? 1'b0 : 1'b1);
      chk("t2_we",   a_we,   1'b1);
      chk("t2_rd",   a_rd,   (k % 2 == 0) ? 5'd1 : 5'd2);
      chk("t2_data", a_data, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("t2_cnt",  a_cnt,  16'(k + 1));
    end
    bus_a.req_valid = 2'b00;
    tick();
    chk("t2_we_end", a_we, 1'b0);

    // x0 write from req1 is consumed silently
    bus_a.req_rd_addr = {5'd0, 5'd1};
    bus_a.req_data    = {32'hDEAD, 32'h100};
    bus_a.req_valid   = 2'b10;
    #1;
    chk("t3_ready", bus_a.req_ready, 2'b10);
    tick();
    bus_a.req_valid = 2'b00;
    chk("t3_we",   a_we,   1'b0);
    chk("t3_cnt",  a_cnt,  16'd4);
    chk("t3_gid",  a_gid,  1'b1);
    chk("t3_data", a_data, 32'hDEAD);

    // req0 alone back-to-back, then req1 joins and wins first
    bus_a.req_rd_addr = {5'd9, 5'd7};
    bus_a.req_data    = {32'h99, 32'h77};
    bus_a.req_valid   = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_ready0", bus_a.req_ready, 2'b01);
      tick();
      chk("t4_we",  a_we,  1'b1);
      chk("t4_gid", a_gid, 1'b0);
      chk("t4_cnt", a_cnt, 16'(5 + k));
    end
    bus_a.req_valid = 2'b11;
    #1;
    chk("t4_ready_join", bus_a.req_ready, 2'b10);
    tick();
    chk("t4_gid_join", a_gid,  1'b1);
    chk("t4_rd_join",  a_rd,   5'd9);
    chk("t4_dat_join", a_data, 32'h99);
    chk("t4_cnt_join", a_cnt,  16'd8);
    #1;
    chk("t4_ready_next", bus_a.req_ready, 2'b01);
    bus_a.req_valid = 2'b00;
    tick();

    // reset on the cycle after acceptance, then the requester retries
    bus_a.req_rd_addr = {5'd0, 5'd3};
    bus_a.req_data    = {32'h0, 32'h33};
    bus_a.req_valid   = 2'b01;
    #1;
    chk("t5_ready", bus_a.req_ready, 2'b01);
    tick();
    chk("t5_we_acc",  a_we,  1'b1);
    chk("t5_cnt_acc", a_cnt, 16'd9);
    rst = 1'b1;
    #1;
    chk("t5_ready_rst", bus_a.req_ready, 2'b00);
    tick();
    chk("t5_we_rst",   a_we,   1'b0);
    chk("t5_cnt_rst",  a_cnt,  16'd0);
    chk("t5_rd_rst",   a_rd,   5'd0);
    chk("t5_data_rst", a_data, 32'h0);
    rst = 1'b0;
    #1;
    chk("t5_ready_retry", bus_a.req_ready, 2'b01);
    tick();
    bus_a.req_valid = 2'b00;
    chk("t5_we_retry",  a_we,  1'b1);
    chk("t5_rd_retry",  a_rd,  5'd3);
    chk("t5_cnt_retry", a_cnt, 16'd1);

    // 2-bit counter saturates at 3 over five committed writes
    bus_b.req_rd_addr = {5'd0, 5'd4};
    bus_b.req_data    = {32'h0, 32'h4};
    bus_b.req_valid   = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_we",  b_we,  1'b1);
      chk("t6_cnt", b_cnt, (k < 3) ? 2'(k + 1) : 2'd3);
    end
    bus_b.req_valid = 2'b00;
    tick();
    chk("t6_we_end",  b_we,  1'b0);
    chk("t6_cnt_end", b_cnt, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
